// File: rtl/sgmii_rate_adapter_ce.sv
// GMII rate adapter on a single 125 MHz clock: clock-enable strobes toward the MAC,
// nibble-to-byte replication toward the PCS and byte-to-nibble decimation back.
module sgmii_rate_adapter_ce #(
  parameter int unsigned P_REP100 = 10,
  parameter int unsigned P_REP10  = 100,
  parameter int unsigned P_CW     = 7
) (
  input  logic       i_GClk,
  input  logic       i_Reset_L,
  input  logic [1:0] i2_Speed,
  output logic       o_TxCE,
  input  logic       i_TxEN,
  input  logic       i_TxER,
  input  logic [7:0] i8_TxD,
  output logic       o_TxEN,
  output logic       o_TxER,
  output logic [7:0] o8_TxD,
  input  logic       i_RxEN,
  input  logic       i_RxER,
  input  logic [7:0] i8_RxD,
  output logic       o_RxCE,
  output logic       o_RxEN,
  output logic       o_RxER,
  output logic [7:0] o8_RxD,
  output logic       o_TxOddNib,
  output logic       o_RxAlignErr
);

  localparam logic [1:0] Spd1000 = 2'b10;
  localparam logic [1:0] Spd100  = 2'b01;
  localparam logic [1:0] SpdRsvd = 2'b11;

  localparam logic [P_CW-1:0] TxLast100 = P_CW'(P_REP100 / 2 - 1);
  localparam logic [P_CW-1:0] TxLast10  = P_CW'(P_REP10 / 2 - 1);
  localparam logic [P_CW-1:0] RxLast100 = P_CW'(P_REP100 - 1);
  localparam logic [P_CW-1:0] RxLast10  = P_CW'(P_REP10 - 1);
  localparam logic [P_CW-1:0] RxHalf100 = P_CW'(P_REP100 / 2);
  localparam logic [P_CW-1:0] RxHalf10  = P_CW'(P_REP10 / 2);

  logic [1:0]      speed_q, speed_d;
  logic [P_CW-1:0] tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d;
  logic            tx_phase_q, tx_phase_d, tx_act_q, tx_act_d, tx_pend_q, tx_pend_d;
  logic [3:0]      tx_lo_q, tx_lo_d;
  logic            tx_lo_en_q, tx_lo_en_d, tx_lo_er_q, tx_lo_er_d;
  logic            tx_en_q, tx_en_d, tx_er_q, tx_er_d, tx_odd_q, tx_odd_d;
  logic [7:0]      txd_q, txd_d, rxd_q, rxd_d;
  logic            rx_act_q, rx_act_d, rx_ce_q, rx_ce_d;
  logic            rx_en_q, rx_en_d, rx_er_q, rx_er_d, rx_align_q, rx_align_d;

  logic            gig, is100, tx_in_act, rx_in_act, tx_ce, tx_sof, tx_hi, rx_sof, speed_ok;
  logic [P_CW-1:0] tx_last, rx_last, rx_half, rx_cnt_eff;

  always_comb begin
    gig        = (speed_q == Spd1000);
    is100      = (speed_q == Spd100);
    tx_last    = is100 ? TxLast100 : TxLast10;
    rx_last    = is100 ? RxLast100 : RxLast10;
    rx_half    = is100 ? RxHalf100 : RxHalf10;
    tx_in_act  = i_TxEN | i_TxER;
    rx_in_act  = i_RxEN | i_RxER;
    tx_ce      = gig | (tx_div_q == '0);
    tx_sof     = 1'b0;
    tx_hi      = 1'b0;
    rx_sof     = 1'b0;
    rx_cnt_eff = rx_cnt_q;

    speed_d    = speed_q;
    tx_div_d   = tx_div_q;
    tx_phase_d = tx_phase_q;
    tx_act_d   = tx_act_q;
    tx_pend_d  = tx_pend_q;
    tx_lo_d    = tx_lo_q;
    tx_lo_en_d = tx_lo_en_q;
    tx_lo_er_d = tx_lo_er_q;
    tx_en_d    = tx_en_q;
    tx_er_d    = tx_er_q;
    txd_d      = txd_q;
    tx_odd_d   = 1'b0;
    rx_cnt_d   = rx_cnt_q;
    rx_act_d   = rx_in_act;
    rx_ce_d    = 1'b0;
    rx_en_d    = rx_en_q;
    rx_er_d    = rx_er_q;
    rxd_d      = rxd_q;
    rx_align_d = 1'b0;

    if (gig) begin
      tx_en_d    = i_TxEN;
      tx_er_d    = i_TxER;
      txd_d      = i8_TxD;
      tx_div_d   = '0;
      tx_phase_d = 1'b0;
      tx_act_d   = 1'b0;
      tx_pend_d  = 1'b0;
    end else begin
      tx_div_d = (tx_div_q == tx_last) ? '0 : tx_div_q + P_CW'(1);
      if (tx_ce) begin
        tx_sof   = tx_in_act & ~tx_act_q;
        tx_hi    = tx_phase_q & ~tx_sof;
        tx_act_d = tx_in_act;
        if (tx_hi) begin
          // Byte boundary: emit the paired byte, or close the frame.
          tx_phase_d = 1'b0;
          tx_pend_d  = 1'b0;
          if (tx_in_act) begin
            txd_d   = {i8_TxD[3:0], tx_lo_q};
            tx_en_d = i_TxEN | tx_lo_en_q;
            tx_er_d = i_TxER | tx_lo_er_q;
          end else begin
            txd_d    = '0;
            tx_en_d  = 1'b0;
            tx_er_d  = 1'b0;
            tx_odd_d = tx_pend_q;
          end
        end else begin
          // A new frame landing on a boundary slot still ends the previous byte there.
          if (tx_phase_q) begin
            txd_d   = '0;
            tx_en_d = 1'b0;
            tx_er_d = 1'b0;
          end
          tx_phase_d = 1'b1;
          tx_pend_d  = tx_in_act;
          tx_lo_d    = i8_TxD[3:0];
          tx_lo_en_d = i_TxEN;
          tx_lo_er_d = i_TxER;
        end
      end
    end

    if (gig) begin
      rx_ce_d  = 1'b1;
      rx_en_d  = i_RxEN;
      rx_er_d  = i_RxER;
      rxd_d    = i8_RxD;
      rx_cnt_d = '0;
    end else begin
      rx_sof     = rx_in_act & ~rx_act_q;
      rx_cnt_eff = rx_sof ? '0 : rx_cnt_q;
      rx_cnt_d   = (rx_cnt_eff == rx_last) ? '0 : rx_cnt_eff + P_CW'(1);
      if (rx_cnt_eff == '0) begin
        rx_ce_d = 1'b1;
        rx_en_d = i_RxEN;
        rx_er_d = i_RxER;
        rxd_d   = {i8_RxD[3:0], i8_RxD[3:0]};
      end else if (rx_cnt_eff == rx_half) begin
        rx_ce_d = 1'b1;
        rx_en_d = i_RxEN;
        rx_er_d = i_RxER;
        rxd_d   = {i8_RxD[7:4], i8_RxD[7:4]};
      end
      rx_align_d = ~rx_in_act & rx_act_q & (rx_cnt_q != '0);
    end

    speed_ok = ~tx_in_act & ~(tx_en_q | tx_er_q) & ~rx_in_act & ~(rx_en_q | rx_er_q) &
               (i2_Speed != SpdRsvd) & (i2_Speed != speed_q);
    if (speed_ok) begin
      speed_d    = i2_Speed;
      tx_div_d   = '0;
      rx_cnt_d   = '0;
      tx_phase_d = 1'b0;
      tx_pend_d  = 1'b0;
      tx_act_d   = 1'b0;
    end
  end

  always_ff @(posedge i_GClk or negedge i_Reset_L) begin
    if (!i_Reset_L) begin
      speed_q    <= Spd1000;
      tx_div_q   <= '0;
      tx_phase_q <= 1'b0;
      tx_act_q   <= 1'b0;
      tx_pend_q  <= 1'b0;
      tx_lo_q    <= '0;
      tx_lo_en_q <= 1'b0;
      tx_lo_er_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      txd_q      <= '0;
      tx_odd_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_act_q   <= 1'b0;
      rx_ce_q    <= 1'b1;
      rx_en_q    <= 1'b0;
      rx_er_q    <= 1'b0;
      rxd_q      <= '0;
      rx_align_q <= 1'b0;
    end else begin
      speed_q    <= speed_d;
      tx_div_q   <= tx_div_d;
      tx_phase_q <= tx_phase_d;
      tx_act_q   <= tx_act_d;
      tx_pend_q  <= tx_pend_d;
      tx_lo_q    <= tx_lo_d;
      tx_lo_en_q <= tx_lo_en_d;
      tx_lo_er_q <= tx_lo_er_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      txd_q      <= txd_d;
      tx_odd_q   <= tx_odd_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_act_q   <= rx_act_d;
      rx_ce_q    <= rx_ce_d;
      rx_en_q    <= rx_en_d;
      rx_er_q    <= rx_er_d;
      rxd_q      <= rxd_d;
      rx_align_q <= rx_align_d;
    end
  end

  assign o_TxCE       = tx_ce;
  assign o_TxEN       = tx_en_q;
  assign o_TxER       = tx_er_q;
  assign o8_TxD       = txd_q;
  assign o_TxOddNib   = tx_odd_q;
  assign o_RxCE       = rx_ce_q;
  assign o_RxEN       = rx_en_q;
  assign o_RxER       = rx_er_q;
  assign o8_RxD       = rxd_q;
  assign o_RxAlignErr = rx_align_q;

endmodule

// File: tb/tb_sgmii_rate_adapter_ce.sv
// Directed bench for sgmii_rate_adapter_ce: 1000/100/10 Tx and Rx paths, deferred and
// reserved speed requests, odd-nibble and alignment flags, asynchronous reset.
module tb_sgmii_rate_adapter_ce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] speed;
  logic       tx_ce, tx_en_i, tx_er_i, tx_en_o, tx_er_o, tx_odd;
  logic [7:0] txd_i, txd_o, rxd_i, rxd_o;
  logic       rx_en_i, rx_er_i, rx_ce, rx_en_o, rx_er_o, rx_align;

  int n_tests = 0;
  int n_fail  = 0;

  always #4 clk = ~clk;

  sgmii_rate_adapter_ce dut (
    .i_GClk      (clk),
    .i_Reset_L   (rst_n),
    .i2_Speed    (speed),
    .o_TxCE      (tx_ce),
    .i_TxEN      (tx_en_i),
    .i_TxER      (tx_er_i),
    .i8_TxD      (txd_i),
    .o_TxEN      (tx_en_o),
    .o_TxER      (tx_er_o),
    .o8_TxD      (txd_o),
    .i_RxEN      (rx_en_i),
    .i_RxER      (rx_er_i),
    .i8_RxD      (rxd_i),
    .o_RxCE      (rx_ce),
    .o_RxEN      (rx_en_o),
    .o_RxER      (rx_er_o),
    .o8_RxD      (rxd_o),
    .o_TxOddNib  (tx_odd),
    .o_RxAlignErr(rx_align)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_txce();
    for (int i = 0; i < 200 && !tx_ce; i++) @(negedge clk);
    check_eq("txce_wait", tx_ce, 1);
  endtask

  // Drives nact nibbles at N=10 from the first CE; expected bytes are nibble pairs.
  task automatic tx_run(input int nact, input logic [15:0] nibs, input string tag);
    int   slot;
    int   nbytes;
    logic exp_en;
    slot   = 0;
    nbytes = nact / 2;
    wait_txce();
    for (int c = 0; c < 40; c++) begin
      exp_en = (c >= 6) && (c < 6 + 10 * nbytes);
      check_eq({tag, "_ce"}, tx_ce, (c % 5) == 0);
      check_eq({tag, "_en"}, tx_en_o, exp_en);
      if (exp_en) check_eq({tag, "_d"}, txd_o, nibs[8 * ((c - 6) / 10) +: 8]);
      check_eq({tag, "_odd"}, tx_odd, (nact % 2 == 1) && (c == 6 + 10 * nbytes));
      if (tx_ce) begin
        tx_en_i = (slot < nact);
        txd_i   = (slot < nact) ? {4'h0, nibs[4 * slot +: 4]} : 8'h00;
        slot++;
      end
      @(negedge clk);
    end
    tx_en_i = 1'b0;
    txd_i   = 8'h00;
  endtask

  // Rx frame of len cycles of 8'hA5 at N=100.
  task automatic rx_run(input int len, input string tag);
    for (int c = 0; c < 105; c++) begin
      rx_en_i = (c < len);
      rxd_i   = 8'hA5;
      @(negedge clk);
      check_eq({tag, "_ce"}, rx_ce, (c == 0) || (c == 50) || (c == 100));
      check_eq({tag, "_en"}, rx_en_o, c < 100);
      check_eq({tag, "_align"}, rx_align, (len != 100) && (c == len));
      if (c == 0) check_eq({tag, "_lo"}, rxd_o, 8'h55);
      if (c == 50) check_eq({tag, "_hi"}, rxd_o, 8'hAA);
    end
    rx_en_i = 1'b0;
  endtask

  initial begin
    int ce_cnt;
    rst_n   = 1'b0;
    speed   = 2'b10;
    tx_en_i = 1'b0;
    tx_er_i = 1'b0;
    txd_i   = 8'h00;
    rx_en_i = 1'b0;
    rx_er_i = 1'b0;
    rxd_i   = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_txce", tx_ce, 1);
    check_eq("rst_rxce", rx_ce, 1);
    check_eq("rst_txen", tx_en_o, 0);
    check_eq("rst_txd", txd_o, 0);
    check_eq("rst_rxen", rx_en_o, 0);
    check_eq("rst_flags", {tx_odd, rx_align, tx_er_o, rx_er_o}, 0);

    rst_n   = 1'b1;
    tx_en_i = 1'b1;
    txd_i   = 8'h55;
    @(negedge clk);
    check_eq("g_txd", txd_o, 8'h55);
    check_eq("g_txen", tx_en_o, 1);
    check_eq("g_txce", tx_ce, 1);
    check_eq("g_rxce", rx_ce, 1);
    tx_en_i = 1'b0;
    txd_i   = 8'h00;
    repeat (2) @(negedge clk);

    speed = 2'b01;
    repeat (3) @(negedge clk);
    tx_run(4, 16'h5D55, "tx4");
    tx_run(3, 16'h0D55, "tx3");

    speed = 2'b00;
    repeat (3) @(negedge clk);
    rx_run(100, "rx100");
    rx_run(95, "rx95");

    // Deferred change: 1000 holds through an Rx frame, 100 applies once both paths idle.
    speed = 2'b10;
    repeat (3) @(negedge clk);
    rx_en_i = 1'b1;
    rxd_i   = 8'h3C;
    @(negedge clk);
    speed = 2'b01;
    for (int i = 0; i < 3; i++) begin
      rxd_i = 8'h10 + 8'(i);
      @(negedge clk);
      check_eq("dfr_rxd", rxd_o, 8'h10 + 8'(i));
      check_eq("dfr_txce", tx_ce, 1);
      check_eq("dfr_rxce", rx_ce, 1);
    end
    rx_en_i = 1'b0;
    @(negedge clk);
    check_eq("dfr_e0_txce", tx_ce, 1);
    check_eq("dfr_e0_rxen", rx_en_o, 0);
    @(negedge clk);
    check_eq("dfr_e1_txce", tx_ce, 1);
    @(negedge clk);
    check_eq("dfr_e2_txce", tx_ce, 0);
    check_eq("dfr_e2_rxce", rx_ce, 1);
    @(negedge clk);
    check_eq("dfr_e3_rxce", rx_ce, 0);

    speed  = 2'b11;
    ce_cnt = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (tx_ce) ce_cnt++;
      @(negedge clk);
    end
    check_eq("rsvd_cecount", ce_cnt, 4);

    speed = 2'b00;
    repeat (3) @(negedge clk);
    wait_txce();
    tx_en_i = 1'b1;
    txd_i   = 8'h05;
    rx_en_i = 1'b1;
    rxd_i   = 8'hA5;
    repeat (60) @(negedge clk);
    check_eq("pre_rst_txen", tx_en_o, 1);
    check_eq("pre_rst_rxen", rx_en_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_txen", tx_en_o, 0);
    check_eq("arst_txd", txd_o, 0);
    check_eq("arst_rxen", rx_en_o, 0);
    check_eq("arst_rxd", rxd_o, 0);
    check_eq("arst_ce", {tx_ce, rx_ce}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    txd_i = 8'hC3;
    @(negedge clk);
    check_eq("post_txd", txd_o, 8'hC3);
    check_eq("post_rxd", rxd_o, 8'hA5);
    check_eq("post_ce", {tx_ce, rx_ce}, 2'b11);
    @(negedge clk);
    check_eq("post_txce2", tx_ce, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sgmii_rate_adapter_ce.md
# sgmii_rate_adapter_ce

Single-clock, parametrised GMII rate adapter between a MAC and the SGMII PCS, running entirely on the 125 MHz i_GClk. It replaces separate MAC Tx/Rx clocks with clock-enable strobes. At 10/100 Mb/s it packs MII nibbles into bytes replicated N times toward the PCS, and decimates replicated PCS bytes back into nibbles. It also applies speed changes only between frames and flags odd-nibble and misaligned frames.

## Interface
- P_REP100, default 10: byte replication factor at 100 Mb/s; must be even and ≥4.
- P_REP10, default 100: byte replication factor at 10 Mb/s; must be even and ≥4.
- P_CW, default 7: divider counter width; must satisfy 2^P_CW > max(P_REP100, P_REP10).
- i_GClk, in, 1: 125 MHz clock. Single clock domain.
- i_Reset_L, in, 1: reset, asynchronous assert, active-low.
- i2_Speed, in, 2: speed request. 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 reserved.
- o_TxCE, out, 1: MAC Tx strobe. MAC Tx inputs are sampled on cycles where it is 1.
- i_TxEN, i_TxER, in, 1 each: MAC transmit enable and error.
- i8_TxD, in, 8: MAC transmit data. Only [3:0] is used at 10/100.
- o_TxEN, o_TxER, out, 1 each: to PCS.
- o8_TxD, out, 8: to PCS.
- i_RxEN, i_RxER, in, 1 each: from PCS.
- i8_RxD, in, 8: from PCS.
- o_RxCE, out, 1: pulses when the MAC Rx outputs update.
- o_RxEN, o_RxER, out, 1 each: to MAC.
- o8_RxD, out, 8: to MAC. Carries {nib,nib} at 10/100.
- o_TxOddNib, out, 1: one-cycle pulse when a Tx frame ends on an unpaired nibble.
- o_RxAlignErr, out, 1: one-cycle pulse when Rx frame length is not a multiple of N.

## Operation
- N = P_REP100 at 100 Mb/s and P_REP10 at 10 Mb/s.
- Active speed r2_Speed:
  - Loads from i2_Speed only when Tx is idle and Rx is idle.
  - Tx idle means the Tx input is inactive and the Tx output is inactive. Rx idle is defined the same way.
  - A reserved value (2'b11) is ignored; the previous speed is kept.
  - On a speed change, both dividers restart at 0.
- Tx at 1000:
  - o_TxCE = 1 constantly.
  - o_Tx* are i_Tx* registered, 1-cycle latency.
- Tx at 10/100:
  - Divider r_TxDiv counts 0..N/2−1 and wraps. o_TxCE = (r_TxDiv==0).
  - Tx active = i_TxEN | i_TxER, sampled on CE.
  - Nibble phase resets on start of frame, so the first active nibble is the low nibble.
  - On the high-nibble CE, {i8_TxD[3:0], low nibble} is loaded into o8_TxD, together with o_TxEN and o_TxER (each the OR of both nibbles' flags).
  - The loaded byte is held for N cycles, i.e. replicated N times.
  - If Tx goes inactive on a low-nibble CE, o_TxEN and o_TxER go to 0 at the next byte boundary.
  - If Tx goes inactive on a high-nibble CE (unpaired low nibble pending), the lone nibble is discarded, o_TxEN and o_TxER go to 0 at that boundary, and o_TxOddNib pulses.
- Rx at 1000:
  - o_RxCE = 1 constantly.
  - o_Rx* are i_Rx* registered.
- Rx at 10/100:
  - Counter r_RxCnt forces 0 on start of frame (rising edge of i_RxEN | i_RxER). Otherwise it counts 0..N−1 and wraps. It free-runs while idle.
  - At count 0, the low nibble i8_RxD[3:0] is captured. At count N/2, the high nibble i8_RxD[7:4] is captured. Each capture also takes i_RxEN and i_RxER.
  - Outputs are registered. o_RxCE pulses on the cycle the outputs update.
  - On end of frame with r_RxCnt ≠ 0, o_RxAlignErr pulses for one cycle. The partial byte is not flushed.

## Timing
- Reset values: all o_* outputs are 0, except o_TxCE = o_RxCE = 1. r2_Speed = 2'b10, both dividers 0, nibble phase low.
- Reset asserted mid-frame: outputs go to reset values immediately, asynchronously. The first frame after reset is taken at 1000.
- Tx latency at 10/100: 1 cycle from the high-nibble CE to the new o8_TxD.
- Rx latency at 10/100: 1 cycle from capture (count 0 or N/2) to the output update and o_RxCE.
- Start of frame coincident with end of frame (one idle cycle at 1000): treated as a fresh frame. Counter goes to 0, no alignment error for the new frame.
- Speed request during a frame: deferred. It is applied on the first cycle on which both paths are idle.
- At 10/100, o_TxCE spacing is exactly N/2 cycles.

## Test plan
- Reset release with i2_Speed = 2'b10: o_TxCE = o_RxCE = 1, and i8_TxD = 8'h55 appears on o8_TxD one cycle later.
- Speed 100, N = 10: MAC nibbles 5,5,D,5 on o_TxCE (every 5 cycles) → o8_TxD = 8'h55 for 10 cycles, then 8'h5D for 10 cycles, then o_TxEN = 0.
- Speed 100 Tx, 3 nibbles → two bytes are not produced. One byte appears, then o_TxEN = 0 and one o_TxOddNib pulse.
- Speed 10, N = 100: i8_RxD = 8'hA5 with i_RxEN for 100 cycles → o8_RxD = 8'h55, then 8'hAA (2 o_RxCE pulses), no alignment error. With 95 cycles instead → o_RxAlignErr pulses once.
- i2_Speed 2'b10 → 2'b01 mid-Rx-frame: 1000 behaviour persists until the frame ends, and 100 applies from the first idle cycle. 2'b11 request → speed unchanged.
- Assert i_Reset_L low mid-frame at 10 Mb/s: all outputs go to reset values immediately, and operation resumes at 1000 after release.
